kf_load_rx: RTL

//  Responder end of the KF load/measure protocol. Accepts the START pulse and

---
 rtl/kf_load_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kf_load_rx.sv
// kf_load_rx: responder end of the KF load/measure protocol.
// Loads NCOEF sign-magnitude coefficient words into a two's-complement bank.
// Each measurement is then offered to the compute engine, and each engine
// result is returned in sign-magnitude on DATA_OUT.
module kf_load_rx #(
    parameter int unsigned W     = 24,
    parameter int unsigned FRAC  = 14,
    parameter int unsigned NCOEF = 20,
    parameter int unsigned ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [W-1:0]     DATA_IN,
    output logic             READY,
    output logic [W-1:0]     DATA_OUT,
    output logic             data_out_valid,
    output logic             cfg_done,
    input  logic [ADDRW-1:0] coef_raddr,
    output logic [W-1:0]     coef_rdata,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [W-1:0]     meas_data,
    input  logic             res_valid,
    input  logic [W-1:0]     res_data
);

    // FRAC only documents the bus format; the words pass through unscaled.
    if (FRAC >= W - 1 || (2 ** ADDRW) < NCOEF) begin : g_param_check
        $error("kf_load_rx: FRAC must be below W-1 and 2**ADDRW must cover NCOEF");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MCAP,
        S_ISSUE,
        S_WAIT_RES,
        S_HOLD
    } state_t;

    state_t           state, state_next;
    logic [W-1:0]     bank [NCOEF];
    logic [ADDRW-1:0] cnt;
    logic             last_word;

    // Sign-magnitude to two's complement; -0 maps to 0.
    function automatic logic [W-1:0] sm2tc(input logic [W-1:0] x);
        logic [W-1:0] mag;
        mag = {1'b0, x[W-2:0]};
        return x[W-1] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude; the most negative value saturates.
    function automatic logic [W-1:0] tc2sm(input logic [W-1:0] v);
        logic [W-1:0] neg;
        neg = -v;
        if (!v[W-1])
            return v;
        else if (v[W-2:0] == '0)
            return '1;
        else
            return {1'b1, neg[W-2:0]};
    endfunction

    assign last_word = (32'(cnt) == NCOEF - 1);
    assign READY     = (state == S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; START from any state restarts the load.
    always_comb begin
        state_next = state;
        if (START) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_IDLE:     state_next = S_IDLE;
                S_LOAD:     if (last_word) state_next = S_MCAP;
                S_MCAP:     state_next = S_ISSUE;
                S_ISSUE:    if (meas_ready) state_next = S_WAIT_RES;
                S_WAIT_RES: if (res_valid) state_next = S_HOLD;
                S_HOLD:     state_next = S_MCAP;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: bank writes, measurement capture, handshake and result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCOEF; i++)
                bank[i] <= '0;
            cnt            <= '0;
            cfg_done       <= 1'b0;
            meas_valid     <= 1'b0;
            meas_data      <= '0;
            DATA_OUT       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            if (START) begin
                cnt        <= '0;
                cfg_done   <= 1'b0;
                meas_valid <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        bank[cnt] <= sm2tc(DATA_IN);
                        cnt       <= cnt + ADDRW'(1);
                        if (last_word)
                            cfg_done <= 1'b1;
                    end
                    S_MCAP: begin
                        meas_data  <= sm2tc(DATA_IN);
                        meas_valid <= 1'b1;
                    end
                    S_ISSUE: begin
                        if (meas_ready)
                            meas_valid <= 1'b0;
                    end
                    S_WAIT_RES: begin
                        if (res_valid) begin
                            DATA_OUT       <= tc2sm(res_data);
                            data_out_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Combinational coefficient read; addresses past the bank read 0.
    always_comb begin
        coef_rdata = '0;
        if (32'(coef_raddr) < NCOEF)
            coef_rdata = bank[coef_raddr];
    end

endmodule
